// File: rtl/magia_tile_launcher.sv
`default_nettype none
// ============================================================================
//  Module      : magia_tile_launcher
//  Description : Per-tile launch and completion controller for the MAGIA
//                mesh. Raises one fetch-enable per tile (broadcast or
//                staggered), detects completion from debounced core_sleep,
//                records per-tile cycle counts and flags a global timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module magia_tile_launcher #(
  parameter int N_TILES  = 16,
  parameter int CNT_W    = 32,
  parameter int GAP_W    = 8,
  parameter int DEBOUNCE = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       start_i,
  input  logic                       clear_i,
  input  logic [N_TILES-1:0]         enable_mask_i,
  input  logic [GAP_W-1:0]           gap_i,
  input  logic [CNT_W-1:0]           timeout_i,
  input  logic [N_TILES-1:0]         core_sleep_i,
  output logic [N_TILES-1:0]         fetch_enable_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       timeout_o,
  output logic [N_TILES-1:0]         done_mask_o,
  output logic [N_TILES*CNT_W-1:0]   tile_cycles_o,
  output logic [CNT_W-1:0]           cycle_count_o
);

  localparam int DEB_W = $clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_RUN    = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                           r_state;
  state_t                           w_state_nxt;
  logic [N_TILES-1:0]               r_mask;
  logic [GAP_W-1:0]                 r_gap;
  logic [CNT_W-1:0]                 r_timeout;
  logic [CNT_W-1:0]                 r_next_at;      // global count at which the next pending tile rises
  logic [N_TILES-1:0]               r_fetch_en;
  logic [N_TILES-1:0]               r_armed;        // tile is past its launch cycle
  logic [N_TILES-1:0]               r_done_mask;
  logic [N_TILES-1:0][CNT_W-1:0]    r_tile_cnt;
  logic [N_TILES*CNT_W-1:0]         r_tile_cycles;
  logic [N_TILES-1:0][DEB_W-1:0]    r_deb;
  logic [CNT_W-1:0]                 r_cycle_cnt;
  logic                             r_busy;
  logic                             r_done;
  logic                             r_timeout_flag;

  logic                             w_active;
  logic                             w_start;
  logic                             w_run;
  logic [N_TILES-1:0]               w_pending;
  logic [N_TILES-1:0]               w_first;
  logic [N_TILES-1:0]               w_start_first;
  logic [N_TILES-1:0]               w_launch;
  logic [N_TILES-1:0]               w_qual;
  logic [N_TILES-1:0]               w_done_mask_nxt;
  logic                             w_all_done;
  logic                             w_tmo_hit;
  logic                             w_timed_out;
  logic [CNT_W-1:0]                 w_cnt_inc;

  assign w_active        = (r_state == S_LAUNCH) || (r_state == S_RUN);
  assign w_start         = (r_state == S_IDLE) && start_i;
  assign w_run           = w_active && !clear_i;
  // Lowest set bit isolates the next tile in ascending launch order.
  assign w_pending       = r_mask & ~r_fetch_en;
  assign w_first         = w_pending & (~w_pending + N_TILES'(1));
  assign w_start_first   = enable_mask_i & (~enable_mask_i + N_TILES'(1));
  assign w_done_mask_nxt = r_done_mask | w_qual;
  assign w_all_done      = ((w_done_mask_nxt & r_mask) == r_mask);
  assign w_tmo_hit       = (r_timeout != '0) && (r_cycle_cnt == r_timeout);
  assign w_cnt_inc       = (r_cycle_cnt == c_cnt_max) ? r_cycle_cnt : r_cycle_cnt + CNT_W'(1);

  // A tile qualifies on the DEBOUNCE-th consecutive sleep sample after its launch cycle.
  always_comb begin
    w_qual = '0;
    for (int i = 0; i < N_TILES; i++) begin
      w_qual[i] = w_active && r_fetch_en[i] && r_armed[i] && !r_done_mask[i] &&
                  core_sleep_i[i] && (r_deb[i] == DEB_W'(DEBOUNCE - 1));
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next state and launch selection; abort beats completion, completion beats timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_launch    = '0;
    w_timed_out = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          if (enable_mask_i == '0) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_LAUNCH;
            w_launch    = (gap_i == '0) ? enable_mask_i : w_start_first;
          end
        end
      end
      S_LAUNCH, S_RUN: begin
        if (clear_i) begin
          w_state_nxt = S_IDLE;
        end else if (w_all_done) begin
          w_state_nxt = S_DONE;
        end else if (w_tmo_hit) begin
          w_state_nxt = S_DONE;
          w_timed_out = 1'b1;
        end else if (r_state == S_LAUNCH) begin
          if (w_pending == '0) begin
            w_state_nxt = S_RUN;
          end else if ((r_gap != '0) && (w_cnt_inc == r_next_at)) begin
            w_launch = w_first;
          end
        end
      end
      S_DONE: begin
        if (clear_i) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Config latch, counters, debounce and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mask         <= '0;
      r_gap          <= '0;
      r_timeout      <= '0;
      r_next_at      <= '0;
      r_fetch_en     <= '0;
      r_armed        <= '0;
      r_done_mask    <= '0;
      r_tile_cnt     <= '0;
      r_tile_cycles  <= '0;
      r_deb          <= '0;
      r_cycle_cnt    <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_timeout_flag <= 1'b0;
    end else begin
      r_busy         <= (w_state_nxt == S_LAUNCH) || (w_state_nxt == S_RUN);
      r_done         <= (w_state_nxt == S_DONE);
      r_timeout_flag <= (w_state_nxt == S_DONE) &&
                        ((r_state == S_DONE) ? r_timeout_flag : w_timed_out);
      if ((w_state_nxt == S_LAUNCH) || (w_state_nxt == S_RUN)) r_fetch_en <= r_fetch_en | w_launch;
      else                                                     r_fetch_en <= '0;

      if (w_start) begin
        r_mask        <= enable_mask_i;
        r_gap         <= gap_i;
        r_timeout     <= timeout_i;
        r_next_at     <= CNT_W'(gap_i);
        r_armed       <= '0;
        r_done_mask   <= '0;
        r_tile_cnt    <= '0;
        r_tile_cycles <= '0;
        r_deb         <= '0;
        r_cycle_cnt   <= '0;
      end else if (w_run) begin
        for (int i = 0; i < N_TILES; i++) begin
          if (r_fetch_en[i]) r_armed[i] <= 1'b1;
          if (w_launch[i]) begin
            r_tile_cnt[i] <= '0;
          end else if (r_fetch_en[i] && !r_done_mask[i]) begin
            r_tile_cnt[i] <= (r_tile_cnt[i] == c_cnt_max) ? r_tile_cnt[i]
                                                          : r_tile_cnt[i] + CNT_W'(1);
          end
          if (r_fetch_en[i] && r_armed[i] && !r_done_mask[i]) begin
            r_deb[i] <= core_sleep_i[i] ? r_deb[i] + DEB_W'(1) : '0;
          end
          if (w_qual[i]) r_tile_cycles[i*CNT_W +: CNT_W] <= r_tile_cnt[i];
        end
        r_done_mask <= w_done_mask_nxt;
        // The count freezes at the value of the last active cycle.
        if (w_state_nxt != S_DONE) r_cycle_cnt <= w_cnt_inc;
        if (w_launch != '0) r_next_at <= r_next_at + CNT_W'(r_gap);
      end
    end
  end

  assign fetch_enable_o = r_fetch_en;
  assign busy_o         = r_busy;
  assign done_o         = r_done;
  assign timeout_o      = r_timeout_flag;
  assign done_mask_o    = r_done_mask;
  assign tile_cycles_o  = r_tile_cycles;
  assign cycle_count_o  = r_cycle_cnt;

endmodule
`default_nettype wire

// File: tb/tb_magia_tile_launcher.sv
`default_nettype none
// ============================================================================
//  Module      : tb_magia_tile_launcher
//  Description : Directed self-checking bench for magia_tile_launcher. Two
//                instances share stimulus: DEBOUNCE=2 and DEBOUNCE=3.
//                Cycle numbering: cyc=0 is the start cycle S, cyc=n is S+n.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_magia_tile_launcher;

  localparam int N  = 16;
  localparam int CW = 32;
  localparam int GW = 8;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          clear = 1'b0;
  logic [N-1:0]  mask  = '0;
  logic [GW-1:0] gap   = '0;
  logic [CW-1:0] tmo   = '0;
  logic [N-1:0]  sleep = '0;

  logic [N-1:0]    fe2, dm2, fe3, dm3;
  logic            busy2, done2, to2, busy3, done3, to3;
  logic [N*CW-1:0] tc2, tc3;
  logic [CW-1:0]   cc2, cc3;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int sleep_from [N];

  always #5 clk = ~clk;

  magia_tile_launcher #(.N_TILES(N), .CNT_W(CW), .GAP_W(GW), .DEBOUNCE(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .clear_i(clear),
    .enable_mask_i(mask), .gap_i(gap), .timeout_i(tmo), .core_sleep_i(sleep),
    .fetch_enable_o(fe2), .busy_o(busy2), .done_o(done2), .timeout_o(to2),
    .done_mask_o(dm2), .tile_cycles_o(tc2), .cycle_count_o(cc2)
  );

  magia_tile_launcher #(.N_TILES(N), .CNT_W(CW), .GAP_W(GW), .DEBOUNCE(3)) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .clear_i(clear),
    .enable_mask_i(mask), .gap_i(gap), .timeout_i(tmo), .core_sleep_i(sleep),
    .fetch_enable_o(fe3), .busy_o(busy3), .done_o(done3), .timeout_o(to3),
    .done_mask_o(dm3), .tile_cycles_o(tc3), .cycle_count_o(cc3)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cyc=%0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [CW-1:0] tcyc(input logic [N*CW-1:0] v, input int i);
    return v[i*CW +: CW];
  endfunction

  // Advance one cycle; sleep inputs follow the per-tile rise cycle table.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) sleep[i] = (sleep_from[i] != 0) && (cyc >= sleep_from[i]);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    clear = 1'b0;
    sleep = '0;
    for (int i = 0; i < N; i++) sleep_from[i] = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic start_run(input logic [N-1:0] m, input logic [GW-1:0] g, input logic [CW-1:0] t);
    mask  = m;
    gap   = g;
    tmo   = t;
    start = 1'b1;
    cyc   = 0;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] pat;

    // Reset state
    do_reset();
    check_eq("rst_fetch", fe2, 0);
    check_eq("rst_busy", busy2, 0);
    check_eq("rst_done", done2, 0);
    check_eq("rst_count", cc2, 0);
    check_eq("rst_tile_cycles", |tc2, 0);

    // Broadcast: tiles 0..3 sleep from launch+10/+20/+5/+7 (launch at cyc 1)
    do_reset();
    sleep_from[0] = 11; sleep_from[1] = 21; sleep_from[2] = 6; sleep_from[3] = 8;
    start_run(16'h000F, 8'd0, 32'd0);
    check_eq("bc_fetch_s1", fe2, 16'h000F);
    check_eq("bc_busy_s1", busy2, 1);
    check_eq("bc_count_s1", cc2, 0);
    while (cyc < 5) tick();
    check_eq("bc_count_s5", cc2, 4);
    while (cyc < 12) tick();
    check_eq("bc_dmask_s12", dm2, 16'h000C);
    tick();
    check_eq("bc_dmask_s13", dm2, 16'h000D);
    while (cyc < 22) tick();
    check_eq("bc_done_s22", done2, 0);
    check_eq("bc_fetch_s22", fe2, 16'h000F);
    tick();
    check_eq("bc_done_s23", done2, 1);
    check_eq("bc_fetch_s23", fe2, 0);
    check_eq("bc_timeout", to2, 0);
    check_eq("bc_busy_s23", busy2, 0);
    check_eq("bc_dmask_s23", dm2, 16'h000F);
    check_eq("bc_tc0", tcyc(tc2, 0), 11);
    check_eq("bc_tc1", tcyc(tc2, 1), 21);
    check_eq("bc_tc2", tcyc(tc2, 2), 6);
    check_eq("bc_tc3", tcyc(tc2, 3), 8);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_eq("bc_clear_done", done2, 0);
    check_eq("bc_clear_dmask_held", dm2, 16'h000F);
    check_eq("bc_clear_tc1_held", tcyc(tc2, 1), 21);

    // Stagger gap=3 over tiles 0,2,5,7, then abort in RUN
    do_reset();
    start_run(16'h00A5, 8'd3, 32'd0);
    check_eq("st_fetch_s1", fe2, 16'h0001);
    while (cyc < 3) tick();
    check_eq("st_fetch_s3", fe2, 16'h0001);
    tick();
    check_eq("st_fetch_s4", fe2, 16'h0005);
    while (cyc < 7) tick();
    check_eq("st_fetch_s7", fe2, 16'h0025);
    while (cyc < 10) tick();
    check_eq("st_fetch_s10", fe2, 16'h00A5);
    check_eq("st_count_s10", cc2, 9);
    while (cyc < 12) tick();
    check_eq("st_busy_s12", busy2, 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_eq("ab_fetch", fe2, 0);
    check_eq("ab_busy", busy2, 0);
    check_eq("ab_done", done2, 0);
    check_eq("ab_timeout", to2, 0);

    // Timeout 50: tile 0 sleeps from launch+5, tile 1 never
    do_reset();
    sleep_from[0] = 6;
    start_run(16'h0003, 8'd0, 32'd50);
    while (cyc < 51) tick();
    check_eq("to_done_s51", done2, 0);
    check_eq("to_fetch_s51", fe2, 16'h0003);
    tick();
    check_eq("to_done_s52", done2, 1);
    check_eq("to_flag", to2, 1);
    check_eq("to_dmask", dm2, 16'h0001);
    check_eq("to_tc0", tcyc(tc2, 0), 6);
    check_eq("to_tc1", tcyc(tc2, 1), 0);
    check_eq("to_fetch_s52", fe2, 0);
    check_eq("to_d3_flag", to3, 1);
    check_eq("to_d3_tc0", tcyc(tc3, 0), 7);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_eq("to_clear_flag", to2, 0);
    check_eq("to_clear_dmask_held", dm2, 16'h0001);

    // Debounce glitch on tile 0: samples 1,1,0,1,1,1 from launch+1
    do_reset();
    pat = 9'h1EC;
    start_run(16'h0001, 8'd0, 32'd0);
    for (int c = 2; c <= 8; c++) begin
      tick();
      sleep[0] = pat[cyc];
      if (cyc == 4) begin
        check_eq("db2_done_s4", done2, 1);
        check_eq("db2_tc0", tcyc(tc2, 0), 2);
      end
      if (cyc == 7) check_eq("db3_done_s7", done3, 0);
      if (cyc == 8) begin
        check_eq("db3_done_s8", done3, 1);
        check_eq("db3_tc0", tcyc(tc3, 0), 6);
        check_eq("db3_timeout", to3, 0);
      end
    end

    // Empty mask
    do_reset();
    start_run(16'h0000, 8'd0, 32'd0);
    check_eq("em_done", done2, 1);
    check_eq("em_busy", busy2, 0);
    check_eq("em_fetch", fe2, 0);
    check_eq("em_timeout", to2, 0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_eq("em_clear_done", done2, 0);
    check_eq("em_clear_fetch", fe2, 0);

    // Asynchronous reset mid-LAUNCH, then a fresh run
    do_reset();
    start_run(16'h00A5, 8'd3, 32'd0);
    while (cyc < 5) tick();
    check_eq("mr_fetch_pre", fe2, 16'h0005);
    rst_n = 1'b0;
    #1;
    check_eq("mr_fetch", fe2, 0);
    check_eq("mr_busy", busy2, 0);
    check_eq("mr_count", cc2, 0);
    check_eq("mr_done", done2, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sleep_from[0] = 3;
    sleep_from[1] = 3;
    start_run(16'h0003, 8'd0, 32'd0);
    check_eq("fr_fetch_s1", fe2, 16'h0003);
    while (cyc < 4) tick();
    check_eq("fr_done_s4", done2, 0);
    tick();
    check_eq("fr_done_s5", done2, 1);
    check_eq("fr_dmask", dm2, 16'h0003);
    check_eq("fr_tc0", tcyc(tc2, 0), 3);
    check_eq("fr_tc1", tcyc(tc2, 1), 3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
